// File: rtl/merge_pair_arbiter.sv
// Round-robin time-sharing of one two-input run merger across NUM_PAIRS stream pairs.
// Optional per-pair run counters (o_runs_done) when MERGE_ARB_STATS_EN is defined.
module merge_pair_arbiter #(
  parameter int NUM_PAIRS  = 4,
  parameter int DATA_WIDTH = 128,
  parameter int PTR_W      = $clog2(NUM_PAIRS)
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic [NUM_PAIRS*2*DATA_WIDTH-1:0] i_left_data,
  input  logic [NUM_PAIRS-1:0]              i_left_empty,
  output logic [NUM_PAIRS-1:0]              o_left_read,
  input  logic [NUM_PAIRS*2*DATA_WIDTH-1:0] i_right_data,
  input  logic [NUM_PAIRS-1:0]              i_right_empty,
  output logic [NUM_PAIRS-1:0]              o_right_read,
  output logic [2*DATA_WIDTH-1:0]           o_mrg_left_data,
  output logic                              o_mrg_left_empty,
  input  logic                              i_mrg_left_read,
  output logic [2*DATA_WIDTH-1:0]           o_mrg_right_data,
  output logic                              o_mrg_right_empty,
  input  logic                              i_mrg_right_read,
  input  logic                              i_mrg_out_write,
  input  logic [2*DATA_WIDTH-1:0]           i_mrg_out_data,
  output logic [PTR_W-1:0]                  o_grant,
  output logic                              o_busy
`ifdef MERGE_ARB_STATS_EN
  ,
  output logic [NUM_PAIRS*16-1:0]           o_runs_done
`endif
);

  localparam int TW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  grant_q, grant_d;
  logic              ldone_q, ldone_d;
  logic              rdone_q, rdone_d;

  logic [TW-1:0]        l_arr [NUM_PAIRS];
  logic [TW-1:0]        r_arr [NUM_PAIRS];
  logic [NUM_PAIRS-1:0] elig;
  logic [TW-1:0]        l_head, r_head;
  logic                 l_term, r_term;
  logic                 l_emp, r_emp;
  logic                 l_rd, r_rd;
  logic                 out_term;
  logic                 found;
  logic [PTR_W-1:0]     pick;
  logic                 run_end;
  logic                 out_hi_unused;

  for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_unpack
    assign l_arr[k] = i_left_data[k*TW +: TW];
    assign r_arr[k] = i_right_data[k*TW +: TW];
  end

  assign elig          = ~i_left_empty & ~i_right_empty;
  assign l_head        = l_arr[grant_q];
  assign r_head        = r_arr[grant_q];
  assign l_term        = (l_head[DATA_WIDTH-1:0] == '0);
  assign r_term        = (r_head[DATA_WIDTH-1:0] == '0);
  assign out_term      = (i_mrg_out_data[DATA_WIDTH-1:0] == '0);
  assign out_hi_unused = ^i_mrg_out_data[TW-1:DATA_WIDTH];

  // First eligible pair after the last one served
  always_comb begin
    logic [PTR_W-1:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 1; i <= NUM_PAIRS; i++) begin
      idx = PTR_W'((int'(ptr_q) + i) % NUM_PAIRS);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    ptr_d             = ptr_q;
    grant_d           = grant_q;
    ldone_d           = ldone_q;
    rdone_d           = rdone_q;
    o_left_read       = '0;
    o_right_read      = '0;
    o_mrg_left_data   = '0;
    o_mrg_right_data  = '0;
    o_mrg_left_empty  = 1'b1;
    o_mrg_right_empty = 1'b1;
    l_emp             = 1'b1;
    r_emp             = 1'b1;
    l_rd              = 1'b0;
    r_rd              = 1'b0;
    run_end           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          ldone_d = 1'b0;
          rdone_d = 1'b0;
          state_d = FEED;
        end
      end
      FEED: begin
        l_emp             = i_left_empty[grant_q] | ldone_q;
        r_emp             = i_right_empty[grant_q] | rdone_q;
        l_rd              = i_mrg_left_read & ~l_emp;
        r_rd              = i_mrg_right_read & ~r_emp;
        o_mrg_left_data   = l_head;
        o_mrg_right_data  = r_head;
        o_mrg_left_empty  = l_emp;
        o_mrg_right_empty = r_emp;
        o_left_read[grant_q]  = l_rd;
        o_right_read[grant_q] = r_rd;
        if (l_rd && l_term) ldone_d = 1'b1;
        if (r_rd && r_term) rdone_d = 1'b1;
        if (ldone_d && rdone_d) state_d = FLUSH;
      end
      FLUSH: begin
        // Run is over only once the merged terminator leaves the merger
        if (i_mrg_out_write && out_term) begin
          ptr_d   = grant_q;
          state_d = IDLE;
          run_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PTR_W'(NUM_PAIRS - 1);
      grant_q <= '0;
      ldone_q <= 1'b0;
      rdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      ldone_q <= ldone_d;
      rdone_q <= rdone_d;
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = (state_q != IDLE);

`ifdef MERGE_ARB_STATS_EN
  logic [15:0] runs_q [NUM_PAIRS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_PAIRS; k++) runs_q[k] <= '0;
    end else if (run_end && runs_q[grant_q] != 16'hFFFF) begin
      runs_q[grant_q] <= runs_q[grant_q] + 16'd1;
    end
  end

  for (genvar k = 0; k < NUM_PAIRS; k++) begin : g_runs
    assign o_runs_done[k*16 +: 16] = runs_q[k];
  end
`endif

endmodule

// File: tb/tb_merge_pair_arbiter.sv
// Directed scoreboard bench for merge_pair_arbiter; the bench also models the
// FWFT FIFOs and the merger.
module tb_merge_pair_arbiter;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int TW = 2 * DW;
  localparam int PW = 2;

  typedef logic [TW-1:0] tup_t;
  typedef struct {
    int g;
    int nl;
    int nr;
  } run_t;

  localparam tup_t TERM = 16'hC300;

  logic             clk;
  logic             rst_n;
  logic [NP*TW-1:0] i_left_data, i_right_data;
  logic [NP-1:0]    i_left_empty, i_right_empty;
  logic [NP-1:0]    o_left_read, o_right_read;
  logic [TW-1:0]    o_mrg_left_data, o_mrg_right_data;
  logic             o_mrg_left_empty, o_mrg_right_empty;
  logic             i_mrg_left_read, i_mrg_right_read;
  logic             i_mrg_out_write;
  logic [TW-1:0]    i_mrg_out_data;
  logic [PW-1:0]    o_grant;
  logic             o_busy;
`ifdef MERGE_ARB_STATS_EN
  logic [NP*16-1:0] o_runs_done;
`endif

  merge_pair_arbiter #(
    .NUM_PAIRS (NP),
    .DATA_WIDTH(DW)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_left_data      (i_left_data),
    .i_left_empty     (i_left_empty),
    .o_left_read      (o_left_read),
    .i_right_data     (i_right_data),
    .i_right_empty    (i_right_empty),
    .o_right_read     (o_right_read),
    .o_mrg_left_data  (o_mrg_left_data),
    .o_mrg_left_empty (o_mrg_left_empty),
    .i_mrg_left_read  (i_mrg_left_read),
    .o_mrg_right_data (o_mrg_right_data),
    .o_mrg_right_empty(o_mrg_right_empty),
    .i_mrg_right_read (i_mrg_right_read),
    .i_mrg_out_write  (i_mrg_out_write),
    .i_mrg_out_data   (i_mrg_out_data),
    .o_grant          (o_grant),
    .o_busy           (o_busy)
`ifdef MERGE_ARB_STATS_EN
    ,
    .o_runs_done      (o_runs_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tup_t lq[NP][$];
  tup_t rq[NP][$];
  run_t exp_q[$];
  run_t cur;
  int   npass = 0, ntot = 0, nfail = 0;
  int   ncyc = 0, t_load = 0;
  int   cnt_l, cnt_r, dly, out_dly;
  bit   active, sl, sr, flush_exp, end_pend, noise, chk_lat;

  function automatic tup_t T(int v);
    logic [7:0] b;
    b = 8'(v);
    return {8'hA5, b};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NP; k++) begin
      i_left_empty[k]  = (lq[k].size() == 0);
      i_right_empty[k] = (rq[k].size() == 0);
      i_left_data[k*TW +: TW]  = (lq[k].size() != 0) ? lq[k][0] : '0;
      i_right_data[k*TW +: TW] = (rq[k].size() != 0) ? rq[k][0] : '0;
    end
  endtask

  task automatic push(int g, int nl, int nr);
    run_t r;
    r.g  = g;
    r.nl = nl;
    r.nr = nr;
    exp_q.push_back(r);
  endtask

  task automatic cyc();
    logic [NP-1:0] el, er, rl, rr;
    tup_t h;
    int   g;
    @(negedge clk);
    ncyc++;
    if (!active && o_busy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", o_busy, 0);
      end else begin
        cur       = exp_q.pop_front();
        active    = 1;
        sl        = 0;
        sr        = 0;
        cnt_l     = 0;
        cnt_r     = 0;
        flush_exp = 0;
        chk("grant", o_grant, cur.g);
        if (chk_lat) begin
          chk("grant_latency", ncyc - t_load, 2);
          chk_lat = 0;
        end
      end
    end
    if (active) begin
      g  = cur.g;
      el = '0;
      er = '0;
      if (!flush_exp) begin
        el[g] = i_mrg_left_read && lq[g].size() != 0 && !sl;
        er[g] = i_mrg_right_read && rq[g].size() != 0 && !sr;
      end
      chk("busy", o_busy, 1);
      chk("grant_hold", o_grant, g);
      chk("left_read", o_left_read, el);
      chk("right_read", o_right_read, er);
      chk("left_empty", o_mrg_left_empty,
          flush_exp || lq[g].size() == 0 || sl);
      chk("right_empty", o_mrg_right_empty,
          flush_exp || rq[g].size() == 0 || sr);
      if (!flush_exp && lq[g].size() != 0)
        chk("left_data", o_mrg_left_data, lq[g][0]);
      if (!flush_exp && rq[g].size() != 0)
        chk("right_data", o_mrg_right_data, rq[g][0]);
      if (flush_exp)
        chk("flush_data", {o_mrg_left_data, o_mrg_right_data}, 0);
    end else begin
      chk("idle_reads", {o_left_read, o_right_read}, 0);
      chk("idle_empty", {o_mrg_left_empty, o_mrg_right_empty}, 2'b11);
    end
    rl = o_left_read;
    rr = o_right_read;
    @(posedge clk);
    #1;
    if (end_pend) begin
      chk("run_end_idle", o_busy, 0);
      chk("left_count", cnt_l, cur.nl);
      chk("right_count", cnt_r, cur.nr);
      active    = 0;
      flush_exp = 0;
      end_pend  = 0;
    end
    for (int k = 0; k < NP; k++) begin
      if (rl[k] && lq[k].size() != 0) begin
        h = lq[k].pop_front();
        if (active && k == cur.g) begin
          cnt_l++;
          if (h[DW-1:0] == 0) sl = 1;
        end
      end
      if (rr[k] && rq[k].size() != 0) begin
        h = rq[k].pop_front();
        if (active && k == cur.g) begin
          cnt_r++;
          if (h[DW-1:0] == 0) sr = 1;
        end
      end
    end
    if (active && !flush_exp && sl && sr) begin
      flush_exp = 1;
      dly       = out_dly;
    end
    if (active && flush_exp) begin
      i_mrg_out_write = 1;
      if (dly == 0) begin
        i_mrg_out_data = TERM;
        end_pend       = 1;
      end else begin
        i_mrg_out_data = T(8'h3C);
        dly--;
      end
    end else begin
      i_mrg_out_write = noise;
      i_mrg_out_data  = TERM;
    end
    drive();
  endtask

  task automatic run_all(int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || active) && n < max) begin
      cyc();
      n++;
    end
    chk("run_drained", exp_q.size() + int'(active), 0);
  endtask

  task automatic clear_all();
    for (int k = 0; k < NP; k++) begin
      lq[k].delete();
      rq[k].delete();
    end
    exp_q.delete();
    active    = 0;
    flush_exp = 0;
    end_pend  = 0;
    i_mrg_out_write = 0;
    drive();
  endtask

  initial begin
    rst_n            = 0;
    i_mrg_left_read  = 1;
    i_mrg_right_read = 1;
    i_mrg_out_write  = 0;
    i_mrg_out_data   = '0;
    noise   = 0;
    chk_lat = 0;
    out_dly = 2;
    clear_all();
    lq[1].push_back(T(4));
    rq[1].push_back(T(4));
    drive();
    #12;
    chk("rst_busy", o_busy, 0);
    chk("rst_grant", o_grant, 0);
    chk("rst_reads", {o_left_read, o_right_read}, 0);
    chk("rst_empty", {o_mrg_left_empty, o_mrg_right_empty}, 2'b11);
    chk("rst_data", {o_mrg_left_data, o_mrg_right_data}, 0);
    clear_all();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // pairs 0 and 2 eligible together
    lq[0].push_back(T(1)); lq[0].push_back(TERM);
    rq[0].push_back(T(2)); rq[0].push_back(TERM);
    lq[2].push_back(T(3)); lq[2].push_back(TERM);
    rq[2].push_back(TERM);
    push(0, 2, 2);
    push(2, 2, 1);
    out_dly = 4;
    t_load  = ncyc;
    chk_lat = 1;
    drive();
    run_all(100);

    // uneven run lengths, output terminators in IDLE/FEED ignored
    noise = 1;
    out_dly = 1;
    lq[1].push_back(T(5)); lq[1].push_back(T(9)); lq[1].push_back(TERM);
    rq[1].push_back(T(3)); rq[1].push_back(TERM);
    push(1, 3, 2);
    drive();
    run_all(100);

    // both terminators read together, FIFOs still hold the next run
    noise = 0;
    out_dly = 3;
    lq[2].push_back(TERM); lq[2].push_back(T(4)); lq[2].push_back(TERM);
    rq[2].push_back(TERM); rq[2].push_back(TERM);
    push(2, 1, 1);
    push(2, 2, 1);
    drive();
    run_all(100);

    // asynchronous reset in FEED with left_done set
    i_mrg_right_read = 0;
    lq[1].push_back(TERM);
    rq[1].push_back(T(7)); rq[1].push_back(TERM);
    push(1, 1, 0);
    drive();
    repeat (3) cyc();
    chk("pre_rst_busy", o_busy, 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_grant", o_grant, 0);
    chk("arst_reads", {o_left_read, o_right_read}, 0);
    chk("arst_empty", {o_mrg_left_empty, o_mrg_right_empty}, 2'b11);
    chk("arst_data", {o_mrg_left_data, o_mrg_right_data}, 0);
    clear_all();
    i_mrg_right_read = 1;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // all pairs eligible for two runs each
    noise = 1;
    out_dly = 0;
    for (int g = 0; g < NP; g++) begin
      lq[g].push_back(T(g + 1)); lq[g].push_back(TERM);
      lq[g].push_back(T(g + 5)); lq[g].push_back(TERM);
      rq[g].push_back(TERM);
      rq[g].push_back(T(9)); rq[g].push_back(TERM);
    end
    for (int r = 0; r < 2; r++)
      for (int g = 0; g < NP; g++)
        push(g, 2, (r == 0) ? 1 : 2);
    drive();
    run_all(300);

`ifdef MERGE_ARB_STATS_EN
    noise = 0;
    rst_n = 0;
    #2;
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("stats_rst", o_runs_done, 0);
    for (int r = 0; r < 3; r++) begin
      lq[3].push_back(TERM);
      rq[3].push_back(TERM);
      push(3, 1, 1);
    end
    drive();
    run_all(200);
    chk("stats_pair3", o_runs_done[63:48], 3);
    chk("stats_others", o_runs_done[47:0], 0);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
